// File: rtl/expr_eval_pkg.sv
// Shared types, character constants and classification helpers for the
// digit/operator expression stream.
package expr_eval_pkg;

  typedef enum logic [1:0] {START, OPND, OPER, ERR} state_t;

  localparam logic [7:0] CH_0    = 8'h30;
  localparam logic [7:0] CH_9    = 8'h39;
  localparam logic [7:0] CH_PLUS = 8'h2B;
  localparam logic [7:0] CH_STAR = 8'h2A;

  function automatic logic is_digit(input logic [7:0] ch);
    return (ch >= CH_0) && (ch <= CH_9);
  endfunction

  function automatic logic is_op(input logic [7:0] ch);
    return (ch == CH_PLUS) || (ch == CH_STAR);
  endfunction

  function automatic logic [3:0] digit_val(input logic [7:0] ch);
    logic [7:0] t;
    t = ch - CH_0;
    return t[3:0];
  endfunction

endpackage

// File: rtl/expr_char_decode.sv
// Combinational character classifier, shared with the recogniser stage.
module expr_char_decode
  import expr_eval_pkg::*;
(
  input  logic [7:0] ch,
  output logic       is_dig,
  output logic       is_plus,
  output logic       is_star,
  output logic       is_bad,
  output logic [3:0] dval
);

  always_comb begin
    is_dig  = is_digit(ch);
    is_plus = (ch == CH_PLUS);
    is_star = (ch == CH_STAR);
    is_bad  = !is_digit(ch) && !is_op(ch);
    dval    = digit_val(ch);
  end

endmodule

// File: rtl/expr_eval.sv
// Streaming evaluator for single-digit '+'/'*' expressions, '*' binding tighter.
// Optional sticky wrap flag built only when EXPR_EVAL_OVF_EN is defined.
module expr_eval
  import expr_eval_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             clr_n,
  input  logic             restart,
  input  logic             in_valid,
  input  logic [7:0]       in,
  output logic [WIDTH-1:0] result,
  output logic             res_valid,
  output logic             err,
  output logic             ovf
);

  logic       dg, pl, st, bad;
  logic [3:0] dval;

  expr_char_decode u_dec (
    .ch(in), .is_dig(dg), .is_plus(pl), .is_star(st), .is_bad(bad), .dval(dval)
  );

  state_t state, nxt;

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n)        state <= START;
    else if (restart)  state <= START;
    else if (in_valid) state <= nxt;
  end

  always_comb begin
    nxt = state;
    unique case (state)
      START, OPND: nxt = dg ? OPER : ERR;
      OPER:        nxt = (bad || dg) ? ERR : OPND;
      default:     nxt = ERR;
    endcase
  end

  always_comb begin
    res_valid = (state == OPER);
    err       = (state == ERR);
  end

  logic [WIDTH-1:0] acc, term, term_new, rsum, asum;
  logic             mul_pend;
  logic [WIDTH-1:0] dext;
  logic             take_dig, take_plus, take_star;

  assign dext      = {{(WIDTH-4){1'b0}}, dval};
  assign take_dig  = in_valid && !restart && dg && (state == START || state == OPND);
  assign take_plus = in_valid && !restart && pl && (state == OPER);
  assign take_star = in_valid && !restart && st && (state == OPER);

`ifdef EXPR_EVAL_OVF_EN
  logic [WIDTH+3:0] prod;
  logic [WIDTH:0]   rsum_w, asum_w;
  logic             ovf_r;

  assign prod     = {4'b0, term} * {4'b0, dext};
  assign term_new = mul_pend ? prod[WIDTH-1:0] : dext;
  assign rsum_w   = {1'b0, acc} + {1'b0, term_new};
  assign asum_w   = {1'b0, acc} + {1'b0, term};
  assign rsum     = rsum_w[WIDTH-1:0];
  assign asum     = asum_w[WIDTH-1:0];

  // Any dropped high bit from either the product or a sum sticks until cleared.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n)       ovf_r <= 1'b0;
    else if (restart) ovf_r <= 1'b0;
    else if ((take_dig && ((mul_pend && prod[WIDTH+3:WIDTH] != 4'd0) || rsum_w[WIDTH])) ||
             (take_plus && asum_w[WIDTH]))
      ovf_r <= 1'b1;
  end
  assign ovf = ovf_r;
`else
  assign term_new = mul_pend ? term * dext : dext;
  assign rsum     = acc + term_new;
  assign asum     = acc + term;
  assign ovf      = 1'b0;
`endif

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      acc      <= '0;
      term     <= '0;
      result   <= '0;
      mul_pend <= 1'b0;
    end else if (restart) begin
      acc      <= '0;
      term     <= '0;
      result   <= '0;
      mul_pend <= 1'b0;
    end else begin
      if (take_dig) begin
        term   <= term_new;
        result <= rsum;
      end
      if (take_plus) begin
        acc      <= asum;
        mul_pend <= 1'b0;
      end
      if (take_star) mul_pend <= 1'b1;
    end
  end

endmodule
